compress_nucleotides: RTL and testbench
=======================================

# compress_nucleotides

Streaming packer that converts ASCII nucleotide characters (A=65, C=67, G=71, T=84) into the team's 2-bit packed read format: A=00, C=01, G=10, T=11, base i at bits [2i+1:2i]. It is the inverse of the packed-to-ASCII decompressor and sits at the host ingress path, turning byte streams into fixed-width packed read words for the downstream correction pipeline. Characters arrive in multi-byte beats over a valid/ready handshake. The finished packed word is held on a valid/ready output until consumed.

## Interface
- LENGTH, 256: bases per packed output word; multiple of BEAT.
- BEAT, 8: characters per input beat; power of two, ≥1.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- char_valid  in  1  input beat valid.
- char_ready  out  1  block accepts beat this cycle.
- chars  in  BEAT*8  characters; chars[7:0] is the earliest base.
- chars_num  in  $clog2(BEAT+1)  valid characters in beat, 1..BEAT; less than BEAT only on a last beat.
- chars_last  in  1  beat ends the current read.
- read_valid  out  1  packed word valid.
- read_ready  in  1  consumer accepts word.
- read  out  LENGTH*2  packed bases; unfilled positions are 00.
- read_count  out  $clog2(LENGTH+1)  number of filled bases, 1..LENGTH.
- read_error  out  1  word contained at least one invalid character, or an overflowing beat.

## Operation
- States: FILL, HOLD. Reset state FILL; ptr = 0; read = 0.
- FILL: char_ready = 1. On char_valid: character k (k < chars_num) encodes into base position ptr+k; ptr += chars_num.
- Invalid character (any byte not in the accepted set) encodes as 00 and sets the error flag for the current word.
- Transition FILL→HOLD when the accepted beat makes ptr+chars_num == LENGTH, or chars_last = 1. read_count latches the final ptr.
- Overflow: if ptr+chars_num > LENGTH, only the characters up to LENGTH are written, the rest are dropped, read_error = 1, and the block goes to HOLD.
- HOLD: char_ready = 0; read_valid = 1; read, read_count, read_error stable. On read_ready: clear read to 0, ptr = 0, clear error, go to FILL.
- A read longer than LENGTH emits successive full words; the next word continues from the following character.
- chars_num = 0 is illegal and is treated as 1.

## Timing
- Reset values: read_valid 0, read 0, read_count 0, read_error 0, char_ready 0 while rst is high, then 1 in the first cycle after rst deasserts.
- One beat accepted per cycle in FILL.
- read_valid rises in the cycle after the completing beat is accepted (latency 1).
- char_ready is 0 for the whole time read_valid is 1. There is no overlap, so one-cycle bubble throughput is by design.
- The earliest next beat is accepted in the cycle after the read_valid && read_ready handshake.
- rst during FILL or HOLD discards the partial or held word and returns to FILL with ptr = 0.
- char_valid and chars_* are ignored when char_ready = 0.

## Configuration
- COMPRESS_NUCLEOTIDES_LOWERCASE_EN:
  - Defined: a/c/g/t (97/99/103/116) encode identically to upper case.
  - Undefined: lowercase characters are invalid, encode as 00, and set read_error.

## Test plan
- Reset, then LENGTH/BEAT beats of "ACGTACGT" with read_ready = 1 -> read_valid 1 cycle after the last beat; every byte of read = 8'hE4; read_count = 256; read_error = 0.
- Single beat "GGT" (chars_num = 3, chars_last = 1) -> read[5:0] = 6'b111010, rest 0, read_count = 3.
- Beat containing 'N' (78) at byte 2, last -> base 2 = 00; read_error = 1; next read clean -> read_error = 0.
- Hold read_ready low 10 cycles while char_valid is held high -> char_ready stays 0; read stable; no beats consumed; the first beat is accepted the cycle after the handshake.
- Lowercase "acgt" last beat -> with the macro: 8'hE4, no error. Without the macro: 8'h00, read_error = 1.
- Assert rst mid-FILL after 5 beats, then send a 1-beat read -> output contains only the new beat, read_count = chars_num.

Source files
------------

// File: rtl/compress_nucleotides.sv
// compress_nucleotides: packs ASCII nucleotide beats (A/C/G/T) into 2-bit
// read words (A=00, C=01, G=10, T=11, base i at bits [2i+1:2i]).
// Optional feature macro: COMPRESS_NUCLEOTIDES_LOWERCASE_EN accepts a/c/g/t
// as their upper-case equivalents; when undefined they count as invalid.
module compress_nucleotides #(
  parameter int unsigned LENGTH = 256,
  parameter int unsigned BEAT   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          char_valid,
  output logic                          char_ready,
  input  logic [BEAT*8-1:0]             chars,
  input  logic [$clog2(BEAT+1)-1:0]     chars_num,
  input  logic                          chars_last,
  output logic                          read_valid,
  input  logic                          read_ready,
  output logic [LENGTH*2-1:0]           read,
  output logic [$clog2(LENGTH+1)-1:0]   read_count,
  output logic                          read_error
);

  localparam int unsigned NUM_W = $clog2(BEAT + 1);
  localparam int unsigned PTR_W = $clog2(LENGTH + 1);
  localparam int unsigned SUM_W = PTR_W + 1;
  localparam int unsigned IDX_W = $clog2(LENGTH * 2);

  typedef enum logic {FILL, HOLD} state_t;

  state_t               state;
  logic [PTR_W-1:0]     ptr;

  logic [NUM_W-1:0]     num_c;
  logic [SUM_W-1:0]     sum_c;
  logic [BEAT*2-1:0]    codes_c;
  logic [BEAT-1:0]      keep_c;
  logic [IDX_W-1:0]     idx_c [BEAT];
  logic                 beat_err_c;
  logic                 overflow_c;
  logic                 done_c;
  logic [PTR_W-1:0]     fill_c;
  logic [2:0]           enc_c;

  // Returns {invalid, code} for one character
  function automatic logic [2:0] encode(input logic [7:0] ch);
    logic [2:0] r;
    case (ch)
      8'd65:   r = 3'b000;
      8'd67:   r = 3'b001;
      8'd71:   r = 3'b010;
      8'd84:   r = 3'b011;
`ifdef COMPRESS_NUCLEOTIDES_LOWERCASE_EN
      8'd97:   r = 3'b000;
      8'd99:   r = 3'b001;
      8'd103:  r = 3'b010;
      8'd116:  r = 3'b011;
`endif
      default: r = 3'b100;
    endcase
    return r;
  endfunction

  // Decode the incoming beat: codes, target bit positions, kept lanes, errors
  always_comb begin
    enc_c      = '0;
    beat_err_c = 1'b0;
    num_c      = (chars_num == '0) ? NUM_W'(1) : chars_num;
    sum_c      = SUM_W'(ptr) + SUM_W'(num_c);
    for (int k = 0; k < BEAT; k++) begin
      enc_c               = encode(chars[8*k +: 8]);
      codes_c[2*k +: 2]   = enc_c[1:0];
      idx_c[k]            = IDX_W'(2 * (int'(ptr) + k));
      keep_c[k]           = (NUM_W'(k) < num_c) && ((int'(ptr) + k) < int'(LENGTH));
      if (keep_c[k] && enc_c[2]) beat_err_c = 1'b1;
    end
    overflow_c = (sum_c > SUM_W'(LENGTH));
    done_c     = (sum_c >= SUM_W'(LENGTH)) || chars_last;
    fill_c     = overflow_c ? PTR_W'(LENGTH) : PTR_W'(sum_c);
  end

  // FILL/HOLD state machine with registered handshake and word outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      ptr        <= '0;
      read       <= '0;
      read_count <= '0;
      read_error <= 1'b0;
      read_valid <= 1'b0;
      char_ready <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          char_ready <= 1'b1;
          if (char_valid && char_ready) begin
            for (int k = 0; k < BEAT; k++) begin
              if (keep_c[k]) read[idx_c[k] +: 2] <= codes_c[2*k +: 2];
            end
            ptr        <= fill_c;
            read_error <= read_error | beat_err_c | overflow_c;
            if (done_c) begin
              state      <= HOLD;
              read_valid <= 1'b1;
              char_ready <= 1'b0;
              read_count <= fill_c;
            end
          end
        end
        HOLD: begin
          if (read_ready) begin
            state      <= FILL;
            ptr        <= '0;
            read       <= '0;
            read_error <= 1'b0;
            read_valid <= 1'b0;
            char_ready <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_compress_nucleotides.sv
// Testbench for compress_nucleotides: directed scenarios plus randomized reads
// checked against a byte-queue reference model.
`timescale 1ns/1ps
module tb_compress_nucleotides;

  localparam int unsigned LENGTH = 256;
  localparam int unsigned BEAT   = 8;
  localparam int unsigned NUM_W  = $clog2(BEAT + 1);
  localparam int unsigned CNT_W  = $clog2(LENGTH + 1);

  typedef logic [7:0] bq_t [$];

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 char_valid = 1'b0;
  logic                 chars_last = 1'b0;
  logic                 read_ready = 1'b0;
  logic [BEAT*8-1:0]    chars = '0;
  logic [NUM_W-1:0]     chars_num = '0;
  logic                 char_ready;
  logic                 read_valid;
  logic                 read_error;
  logic [LENGTH*2-1:0]  read;
  logic [CNT_W-1:0]     read_count;

  int checks   = 0;
  int failures = 0;

  compress_nucleotides #(.LENGTH(LENGTH), .BEAT(BEAT)) dut (
    .clk(clk), .rst(rst),
    .char_valid(char_valid), .char_ready(char_ready),
    .chars(chars), .chars_num(chars_num), .chars_last(chars_last),
    .read_valid(read_valid), .read_ready(read_ready),
    .read(read), .read_count(read_count), .read_error(read_error)
  );

  always #5 clk = ~clk;

  // Reference: character -> 2-bit code by position in the alphabet string
  function automatic void model_char(input logic [7:0] b, output logic [1:0] code, output logic bad);
    string up = "ACGT";
    string lo = "acgt";
    code = 2'b00;
    bad  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b == up[i]) begin code = 2'(i); bad = 1'b0; end
`ifdef COMPRESS_NUCLEOTIDES_LOWERCASE_EN
      if (b == lo[i]) begin code = 2'(i); bad = 1'b0; end
`else
      if (b == lo[i]) bad = 1'b1;
`endif
    end
  endfunction

  // Reference: whole word from the list of its characters
  function automatic void model_word(input bq_t q, output logic [LENGTH*2-1:0] w,
                                     output int n, output logic err);
    logic [1:0] c;
    logic       b;
    w   = '0;
    n   = q.size();
    err = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      model_char(q[i], c, b);
      w[2*i +: 2] = c;
      err = err | b;
    end
  endfunction

  function automatic bq_t str_q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic logic [7:0] rand_char();
    int r = $urandom_range(0, 19);
    string up = "ACGT";
    string lo = "acgt";
    if (r < 16) return up[r % 4];
    if (r < 18) return lo[r % 4];
    if (r == 18) return 8'd78;
    return 8'($urandom_range(0, 255));
  endfunction

  // Present a beat from a negedge; returns at the negedge after it is taken
  task automatic send_beat(input bq_t q, input logic last, output logic to);
    int wait_n = 0;
    chars = '0;
    for (int k = 0; k < q.size(); k++) chars[8*k +: 8] = q[k];
    chars_num  = NUM_W'(q.size());
    chars_last = last;
    char_valid = 1'b1;
    while (!char_ready && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    to = !char_ready;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic wait_read(input int budget, output logic to);
    int n = 0;
    while (!read_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    to = !read_valid;
  endtask

  task automatic handshake();
    read_ready = 1'b1;
    @(negedge clk);
    read_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (read_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", read_valid); end
    checks++; if (read !== '0) begin failures++; $display("FAIL reset_read got %h want 0", read); end
    checks++; if (read_count !== '0) begin failures++; $display("FAIL reset_count got %0d want 0", read_count); end
    checks++; if (read_error !== 1'b0) begin failures++; $display("FAIL reset_error got %b want 0", read_error); end
    checks++; if (char_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_in_rst got %b want 0", char_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (char_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got %b want 1", char_ready); end
  endtask

  task automatic test_full();
    bq_t q = str_q("ACGTACGT");
    bq_t all;
    logic to, to_any = 1'b0, e;
    logic [LENGTH*2-1:0] w;
    int n, bad_bytes = 0;
    for (int i = 0; i < LENGTH / BEAT; i++) begin
      if (i == LENGTH / BEAT - 1) begin
        checks++; if (read_valid !== 1'b0) begin failures++; $display("FAIL full_early_valid got %b want 0", read_valid); end
      end
      send_beat(q, 1'b0, to);
      to_any = to_any | to;
      for (int k = 0; k < q.size(); k++) all.push_back(q[k]);
    end
    model_word(all, w, n, e);
    checks++; if (to_any !== 1'b0) begin failures++; $display("FAIL full_accept_timeout got %b want 0", to_any); end
    checks++; if (read_valid !== 1'b1) begin failures++; $display("FAIL full_latency got %b want 1", read_valid); end
    checks++; if (char_ready !== 1'b0) begin failures++; $display("FAIL full_ready_low got %b want 0", char_ready); end
    checks++; if (read !== w) begin failures++; $display("FAIL full_read got %h want %h", read, w); end
    for (int b = 0; b < LENGTH * 2 / 8; b++) if (read[8*b +: 8] !== 8'hE4) bad_bytes++;
    checks++; if (bad_bytes !== 0) begin failures++; $display("FAIL full_bytes_e4 got %0d bad bytes want 0", bad_bytes); end
    checks++; if (read_count !== CNT_W'(n)) begin failures++; $display("FAIL full_count got %0d want %0d", read_count, n); end
    checks++; if (read_error !== e) begin failures++; $display("FAIL full_error got %b want %b", read_error, e); end
    handshake();
  endtask

  task automatic test_ggt();
    logic to;
    logic [LENGTH*2-1:0] exp = '0;
    exp[5:0] = 6'b111010;
    send_beat(str_q("GGT"), 1'b1, to);
    checks++; if (read_valid !== 1'b1) begin failures++; $display("FAIL ggt_valid got %b want 1", read_valid); end
    checks++; if (read !== exp) begin failures++; $display("FAIL ggt_read got %h want %h", read, exp); end
    checks++; if (read_count !== CNT_W'(3)) begin failures++; $display("FAIL ggt_count got %0d want 3", read_count); end
    checks++; if (read_error !== 1'b0) begin failures++; $display("FAIL ggt_error got %b want 0", read_error); end
    handshake();
  endtask

  task automatic test_invalid();
    logic to, e;
    logic [LENGTH*2-1:0] w;
    int n;
    bq_t q = str_q("ACNTACGT");
    model_word(q, w, n, e);
    send_beat(q, 1'b1, to);
    checks++; if (read[5:4] !== 2'b00) begin failures++; $display("FAIL invalid_base2 got %b want 00", read[5:4]); end
    checks++; if (read !== w) begin failures++; $display("FAIL invalid_read got %h want %h", read, w); end
    checks++; if (read_error !== 1'b1) begin failures++; $display("FAIL invalid_error got %b want 1", read_error); end
    handshake();
    q = str_q("TTTT");
    model_word(q, w, n, e);
    send_beat(q, 1'b1, to);
    checks++; if (read_error !== 1'b0) begin failures++; $display("FAIL invalid_next_clean got %b want 0", read_error); end
    checks++; if (read !== w) begin failures++; $display("FAIL invalid_next_read got %h want %h", read, w); end
    handshake();
  endtask

  task automatic test_backpressure();
    logic to, e;
    logic [LENGTH*2-1:0] held, w;
    int n;
    bq_t q;
    send_beat(str_q("CCGG"), 1'b1, to);
    held = read;
    model_word(str_q("CCGG"), w, n, e);
    checks++; if (held !== w) begin failures++; $display("FAIL bp_first_read got %h want %h", held, w); end
    q = str_q("TGCA");
    chars = '0;
    for (int k = 0; k < 4; k++) chars[8*k +: 8] = q[k];
    chars_num  = NUM_W'(4);
    chars_last = 1'b1;
    char_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (char_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cycle %0d got %b want 0", c, char_ready); end
      checks++; if (read_valid !== 1'b1 || read !== held) begin failures++; $display("FAIL bp_stable cycle %0d valid %b read %h want 1 %h", c, read_valid, read, held); end
    end
    read_ready = 1'b1;
    @(negedge clk);
    read_ready = 1'b0;
    checks++; if (read_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got %b want 0", read_valid); end
    checks++; if (char_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got %b want 1", char_ready); end
    @(negedge clk);
    char_valid = 1'b0;
    model_word(q, w, n, e);
    checks++; if (read_valid !== 1'b1) begin failures++; $display("FAIL bp_next_valid got %b want 1", read_valid); end
    checks++; if (read !== w) begin failures++; $display("FAIL bp_next_read got %h want %h", read, w); end
    checks++; if (read_count !== CNT_W'(n)) begin failures++; $display("FAIL bp_next_count got %0d want %0d", read_count, n); end
    handshake();
  endtask

  task automatic test_lowercase();
    logic to;
    logic [7:0] exp_byte;
    logic       exp_err;
`ifdef COMPRESS_NUCLEOTIDES_LOWERCASE_EN
    exp_byte = 8'hE4;
    exp_err  = 1'b0;
`else
    exp_byte = 8'h00;
    exp_err  = 1'b1;
`endif
    send_beat(str_q("acgt"), 1'b1, to);
    checks++; if (read[7:0] !== exp_byte) begin failures++; $display("FAIL lower_byte got %h want %h", read[7:0], exp_byte); end
    checks++; if (read_error !== exp_err) begin failures++; $display("FAIL lower_error got %b want %b", read_error, exp_err); end
    checks++; if (read_count !== CNT_W'(4)) begin failures++; $display("FAIL lower_count got %0d want 4", read_count); end
    handshake();
  endtask

  task automatic test_mid_reset();
    logic to, e;
    logic [LENGTH*2-1:0] w;
    int n, len;
    bq_t q;
    for (int i = 0; i < 5; i++) begin
      q = {};
      for (int k = 0; k < BEAT; k++) q.push_back(8'd65 + 8'(2 * (k % 2)));
      send_beat(q, 1'b0, to);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (read_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got %b want 0", read_valid); end
    checks++; if (char_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got %b want 1", char_ready); end
    len = $urandom_range(1, BEAT);
    q = {};
    for (int k = 0; k < len; k++) q.push_back(rand_char());
    model_word(q, w, n, e);
    send_beat(q, 1'b1, to);
    checks++; if (read !== w) begin failures++; $display("FAIL midrst_read got %h want %h", read, w); end
    checks++; if (read_count !== CNT_W'(len)) begin failures++; $display("FAIL midrst_count got %0d want %0d", read_count, len); end
    checks++; if (read_error !== e) begin failures++; $display("FAIL midrst_error got %b want %b", read_error, e); end
    handshake();
  endtask

  task automatic test_random();
    bq_t flat, chunk;
    int lens[$];
    logic [LENGTH*2-1:0] exp_w_q[$];
    int exp_n_q[$];
    logic exp_e_q[$];
    logic [LENGTH*2-1:0] w;
    int n, base = 0;
    logic e;
    for (int r = 0; r < 20; r++) begin
      int len = (r % 5 == 0) ? int'(LENGTH) * ($urandom_range(1, 2)) : $urandom_range(1, 520);
      lens.push_back(len);
      for (int i = 0; i < len; i++) flat.push_back(rand_char());
      for (int off = 0; off < len; off += LENGTH) begin
        chunk = {};
        for (int i = off; i < len && i < off + int'(LENGTH); i++) chunk.push_back(flat[base + i]);
        model_word(chunk, w, n, e);
        exp_w_q.push_back(w);
        exp_n_q.push_back(n);
        exp_e_q.push_back(e);
      end
      base += len;
    end
    fork
      begin : sender
        int p = 0;
        logic to;
        bq_t beat;
        foreach (lens[r]) begin
          for (int off = 0; off < lens[r]; off += BEAT) begin
            beat = {};
            for (int i = off; i < lens[r] && i < off + int'(BEAT); i++) beat.push_back(flat[p + i]);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send_beat(beat, (off + int'(BEAT) >= lens[r]), to);
            checks++; if (to !== 1'b0) begin failures++; $display("FAIL rand_accept_timeout read %0d off %0d", r, off); end
          end
          p += lens[r];
        end
      end
      begin : receiver
        logic to;
        for (int wi = 0; wi < exp_w_q.size(); wi++) begin
          wait_read(3000, to);
          checks++; if (to !== 1'b0) begin failures++; $display("FAIL rand_word_timeout word %0d", wi); end
          checks++; if (read !== exp_w_q[wi]) begin failures++; $display("FAIL rand_read word %0d got %h want %h", wi, read, exp_w_q[wi]); end
          checks++; if (read_count !== CNT_W'(exp_n_q[wi])) begin failures++; $display("FAIL rand_count word %0d got %0d want %0d", wi, read_count, exp_n_q[wi]); end
          checks++; if (read_error !== exp_e_q[wi]) begin failures++; $display("FAIL rand_error word %0d got %b want %b", wi, read_error, exp_e_q[wi]); end
          repeat ($urandom_range(0, 3)) @(negedge clk);
          handshake();
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_full();
    test_ggt();
    test_invalid();
    test_backpressure();
    test_lowercase();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
